// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stages: datapath widths, the
// memory-stage FSM state type and the bundle of EX/MEM fields that the
// memory stage captures while an access is outstanding.
package pipeline_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2
   } mem_state_e;

   // EX/MEM fields captured for the duration of a memory access.
   typedef struct packed {
      logic                  reg_write;
      logic                  mem_write;
      logic                  result_src;
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       pc_plus4;
      logic [XLEN-1:0]       wdata;
      logic [XLEN-1:0]       alu_result;
   } exmem_t;

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register.
// Ports:
//   clk, rst        clock and synchronous active-high reset (clears all fields)
//   load_en_i       capture all *_i fields at the next edge
//   bubble_i        insert a bubble: clear the control bits, hold the data
//   *_i             next MEM/WB contents
//   *_o             registered MEM/WB contents
// A bubble takes priority over a load.
module mem_wb_register
   import pipeline_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_en_i,
   input  logic                  bubble_i,
   input  logic                  reg_write_i,
   input  logic                  result_src_i,
   input  logic [REG_ADDR_W-1:0] rd_i,
   input  logic [XLEN-1:0]       pc_plus4_i,
   input  logic [XLEN-1:0]       alu_result_i,
   input  logic [XLEN-1:0]       read_data_i,
   output logic                  reg_write_o,
   output logic                  result_src_o,
   output logic [REG_ADDR_W-1:0] rd_o,
   output logic [XLEN-1:0]       pc_plus4_o,
   output logic [XLEN-1:0]       alu_result_o,
   output logic [XLEN-1:0]       read_data_o
);

   logic                  reg_write_q;
   logic                  result_src_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [XLEN-1:0]       pc_plus4_q;
   logic [XLEN-1:0]       alu_result_q;
   logic [XLEN-1:0]       read_data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_write_q  <= 1'b0;
         result_src_q <= 1'b0;
         rd_q         <= '0;
         pc_plus4_q   <= '0;
         alu_result_q <= '0;
         read_data_q  <= '0;
      end else if (bubble_i) begin
         reg_write_q  <= 1'b0;
         result_src_q <= 1'b0;
      end else if (load_en_i) begin
         reg_write_q  <= reg_write_i;
         result_src_q <= result_src_i;
         rd_q         <= rd_i;
         pc_plus4_q   <= pc_plus4_i;
         alu_result_q <= alu_result_i;
         read_data_q  <= read_data_i;
      end
   end

   assign reg_write_o  = reg_write_q;
   assign result_src_o = result_src_q;
   assign rd_o         = rd_q;
   assign pc_plus4_o   = pc_plus4_q;
   assign alu_result_o = alu_result_q;
   assign read_data_o  = read_data_q;

endmodule

// File: rtl/memory_cycle.sv
// Memory stage of the five-stage RISC-V pipeline.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   RegWriteM..ALU_ResultM      EX/MEM register outputs
//   dmem_req_*/dmem_we/addr/
//   wdata/dmem_rsp_*            valid/ready data-memory bus
//   StallM                      holds the upstream pipeline while an access is pending
//   BusErrorM                   sticky: some access timed out (cleared only by rst)
//   RegWriteW..ReadDataW        MEM/WB register outputs
// A load or store is issued straight from the EX/MEM inputs in IDLE; if it
// cannot finish in that cycle the inputs are replayed from a hold register.
// A timeout counter forces completion so the pipeline never deadlocks.
module memory_cycle
   import pipeline_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RegWriteM,
   input  logic                  MemWriteM,
   input  logic                  ResultSrcM,
   input  logic [REG_ADDR_W-1:0] RD_M,
   input  logic [XLEN-1:0]       PCPlus4M,
   input  logic [XLEN-1:0]       WriteDataM,
   input  logic [XLEN-1:0]       ALU_ResultM,
   output logic                  dmem_req_valid,
   input  logic                  dmem_req_ready,
   output logic                  dmem_we,
   output logic [XLEN-1:0]       dmem_addr,
   output logic [XLEN-1:0]       dmem_wdata,
   input  logic                  dmem_rsp_valid,
   input  logic [XLEN-1:0]       dmem_rsp_rdata,
   output logic                  StallM,
   output logic                  BusErrorM,
   output logic                  RegWriteW,
   output logic                  ResultSrcW,
   output logic [REG_ADDR_W-1:0] RD_W,
   output logic [XLEN-1:0]       PCPlus4W,
   output logic [XLEN-1:0]       ALU_ResultW,
   output logic [XLEN-1:0]       ReadDataW
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   mem_state_e       state_q, state_d;
   exmem_t           hold_q, in_w;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bus_err_q, bus_err_d;
   logic             complete_w, expire_w, from_in_w;
   logic [XLEN-1:0]  rdata_w;

   assign in_w = {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM};

   // Counter reads TIMEOUT_CYCLES-1 in the TIMEOUT_CYCLES-th cycle spent
   // in REQ/WAIT_RSP. It can step once past that when a load is accepted
   // in its expiry cycle; that load then gets one cycle for its response.
   assign expire_w  = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
   assign from_in_w = (state_q == IDLE);

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      bus_err_d      = bus_err_q;
      dmem_req_valid = 1'b0;
      dmem_we        = 1'b0;
      dmem_addr      = '0;
      dmem_wdata     = '0;
      complete_w     = 1'b0;
      rdata_w        = '0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (in_w.mem_write || in_w.result_src) begin
               dmem_req_valid = 1'b1;
               dmem_we        = in_w.mem_write;
               dmem_addr      = in_w.alu_result;
               dmem_wdata     = in_w.wdata;
               // Store wins when both store and load flags are set.
               if (in_w.mem_write) begin
                  if (dmem_req_ready) complete_w = 1'b1;
                  else                state_d    = REQ;
               end else begin
                  state_d = dmem_req_ready ? WAIT_RSP : REQ;
               end
            end else begin
               complete_w = 1'b1;
            end
         end

         REQ: begin
            cnt_d          = cnt_q + CNT_W'(1);
            dmem_req_valid = 1'b1;
            dmem_we        = hold_q.mem_write;
            dmem_addr      = hold_q.alu_result;
            dmem_wdata     = hold_q.wdata;
            if (dmem_req_ready) begin
               if (hold_q.mem_write) begin
                  complete_w = 1'b1;
                  state_d    = IDLE;
               end else begin
                  state_d = WAIT_RSP;
               end
            end else if (expire_w) begin
               complete_w = 1'b1;
               bus_err_d  = 1'b1;
               state_d    = IDLE;
            end
         end

         WAIT_RSP: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (dmem_rsp_valid) begin
               complete_w = 1'b1;
               rdata_w    = dmem_rsp_rdata;
               state_d    = IDLE;
            end else if (expire_w) begin
               complete_w = 1'b1;
               bus_err_d  = 1'b1;
               state_d    = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase

      if (rst) dmem_req_valid = 1'b0;
   end

   assign StallM    = !complete_w && !rst;
   assign BusErrorM = bus_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bus_err_q <= bus_err_d;
         if (from_in_w) hold_q <= in_w;
      end
   end

   // Completion out of IDLE takes the live inputs; completion of a
   // held access takes the hold register.
   mem_wb_register u_mem_wb (
      .clk          (clk),
      .rst          (rst),
      .load_en_i    (complete_w),
      .bubble_i     (StallM),
      .reg_write_i  (from_in_w ? in_w.reg_write  : hold_q.reg_write),
      .result_src_i (from_in_w ? in_w.result_src : hold_q.result_src),
      .rd_i         (from_in_w ? in_w.rd         : hold_q.rd),
      .pc_plus4_i   (from_in_w ? in_w.pc_plus4   : hold_q.pc_plus4),
      .alu_result_i (from_in_w ? in_w.alu_result : hold_q.alu_result),
      .read_data_i  (rdata_w),
      .reg_write_o  (RegWriteW),
      .result_src_o (ResultSrcW),
      .rd_o         (RD_W),
      .pc_plus4_o   (PCPlus4W),
      .alu_result_o (ALU_ResultW),
      .read_data_o  (ReadDataW)
   );

endmodule

// File: tb/tb_memory_cycle.sv
module tb_memory_cycle;

   localparam int TO = 4;

   typedef struct packed {
      logic        rw, mw, rs;
      logic [4:0]  rd;
      logic [31:0] pc, wd, alu;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWriteM, MemWriteM, ResultSrcM;
   logic [4:0]  RD_M;
   logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
   logic        dmem_req_valid, dmem_req_ready, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rsp_rdata;
   logic        StallM, BusErrorM, RegWriteW, ResultSrcW;
   logic [4:0]  RD_W;
   logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   memory_cycle #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
      .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
      .StallM(StallM), .BusErrorM(BusErrorM),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
      .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; RD_M = 0;
      PCPlus4M = 0; WriteDataM = 0; ALU_ResultM = 0;
      dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_rdata = 0;
   endtask

   task automatic drive(input txn_t t);
      RegWriteM = t.rw; MemWriteM = t.mw; ResultSrcM = t.rs; RD_M = t.rd;
      PCPlus4M = t.pc; WriteDataM = t.wd; ALU_ResultM = t.alu;
   endtask

   task automatic test_reset();
      drive('{rw:1, mw:0, rs:1, rd:5'd7, pc:32'h44, wd:32'h1, alu:32'h80});
      dmem_req_ready = 1; rst = 1;
      #1;
      total++; if (dmem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", dmem_req_valid); end
      total++; if (StallM !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b exp=0", StallM); end
      tick(); tick();
      total++; if ({RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW} !== '0) begin bad++;
         $display("FAIL rst_wb got=%h exp=0", {RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW}); end
      total++; if (BusErrorM !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", BusErrorM); end
      rst = 0; idle_inputs();
      tick();
   endtask

   task automatic test_alu();
      drive('{rw:1, mw:0, rs:0, rd:5'd5, pc:32'h104, wd:32'h0, alu:32'h2A});
      #1;
      total++; if (dmem_req_valid !== 1'b0) begin bad++; $display("FAIL alu_valid got=%0b exp=0", dmem_req_valid); end
      total++; if (StallM !== 1'b0) begin bad++; $display("FAIL alu_stall got=%0b exp=0", StallM); end
      tick(); idle_inputs();
      total++; if ({RegWriteW, RD_W, ALU_ResultW, ReadDataW} !== {1'b1, 5'd5, 32'h2A, 32'h0}) begin bad++;
         $display("FAIL alu_wb got=%0b/%0d/%h/%h exp=1/5/2a/0", RegWriteW, RD_W, ALU_ResultW, ReadDataW); end
   endtask

   task automatic test_store_zero_wait();
      drive('{rw:0, mw:1, rs:0, rd:5'd0, pc:32'h108, wd:32'hDEADBEEF, alu:32'h100});
      dmem_req_ready = 1;
      #1;
      total++; if ({dmem_req_valid, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF}) begin bad++;
         $display("FAIL st0_req got=%0b/%0b/%h/%h exp=1/1/100/deadbeef", dmem_req_valid, dmem_we, dmem_addr, dmem_wdata); end
      total++; if (StallM !== 1'b0) begin bad++; $display("FAIL st0_stall got=%0b exp=0", StallM); end
      tick(); idle_inputs();
      #1;
      total++; if (dmem_req_valid !== 1'b0) begin bad++; $display("FAIL st0_single got=%0b exp=0", dmem_req_valid); end
      total++; if ({RegWriteW, ALU_ResultW, PCPlus4W} !== {1'b0, 32'h100, 32'h108}) begin bad++;
         $display("FAIL st0_wb got=%0b/%h/%h exp=0/100/108", RegWriteW, ALU_ResultW, PCPlus4W); end
   endtask

   task automatic test_store_backpressure();
      drive('{rw:1, mw:1, rs:0, rd:5'd11, pc:32'h10C, wd:32'hCAFEF00D, alu:32'h300});
      dmem_req_ready = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (StallM !== 1'b1) begin bad++; $display("FAIL stbp_stall%0d got=%0b exp=1", i, StallM); end
         total++; if ({dmem_req_valid, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 32'h300, 32'hCAFEF00D}) begin bad++;
            $display("FAIL stbp_req%0d got=%0b/%0b/%h/%h exp=1/1/300/cafef00d", i, dmem_req_valid, dmem_we, dmem_addr, dmem_wdata); end
         tick();
         // upstream garbage must not disturb the held request
         drive('{rw:0, mw:0, rs:1, rd:5'd31, pc:32'hFFFF, wd:32'h5A5A, alu:32'hFFF0});
         total++; if ({RegWriteW, ALU_ResultW} !== {1'b0, 32'h100}) begin bad++;
            $display("FAIL stbp_bubble%0d got=%0b/%h exp=0/100", i, RegWriteW, ALU_ResultW); end
      end
      dmem_req_ready = 1;
      #1;
      total++; if ({StallM, dmem_req_valid, dmem_addr} !== {1'b0, 1'b1, 32'h300}) begin bad++;
         $display("FAIL stbp_done got=%0b/%0b/%h exp=0/1/300", StallM, dmem_req_valid, dmem_addr); end
      tick(); idle_inputs();
      total++; if ({RegWriteW, RD_W, ALU_ResultW, ReadDataW} !== {1'b1, 5'd11, 32'h300, 32'h0}) begin bad++;
         $display("FAIL stbp_wb got=%0b/%0d/%h/%h exp=1/11/300/0", RegWriteW, RD_W, ALU_ResultW, ReadDataW); end
   endtask

   task automatic test_load();
      drive('{rw:1, mw:0, rs:1, rd:5'd9, pc:32'h110, wd:32'h0, alu:32'h200});
      dmem_req_ready = 1;
      dmem_rsp_valid = 1; dmem_rsp_rdata = 32'hBAD0BAD0;   // not sampled in the acceptance cycle
      #1;
      total++; if ({StallM, dmem_req_valid, dmem_we, dmem_addr} !== {1'b1, 1'b1, 1'b0, 32'h200}) begin bad++;
         $display("FAIL ld_req got=%0b/%0b/%0b/%h exp=1/1/0/200", StallM, dmem_req_valid, dmem_we, dmem_addr); end
      tick(); idle_inputs();
      #1;
      total++; if ({StallM, dmem_req_valid, RegWriteW} !== 3'b100) begin bad++;
         $display("FAIL ld_wait got=%0b/%0b/%0b exp=1/0/0", StallM, dmem_req_valid, RegWriteW); end
      tick();
      dmem_rsp_valid = 1; dmem_rsp_rdata = 32'h12345678;
      #1;
      total++; if (StallM !== 1'b0) begin bad++; $display("FAIL ld_done got=%0b exp=0", StallM); end
      tick(); idle_inputs();
      total++; if ({RegWriteW, ResultSrcW, RD_W, ReadDataW, ALU_ResultW} !== {1'b1, 1'b1, 5'd9, 32'h12345678, 32'h200}) begin bad++;
         $display("FAIL ld_wb got=%0b/%0b/%0d/%h/%h exp=1/1/9/12345678/200", RegWriteW, ResultSrcW, RD_W, ReadDataW, ALU_ResultW); end
   endtask

   task automatic test_timeout();
      drive('{rw:1, mw:0, rs:1, rd:5'd12, pc:32'h40, wd:32'h0, alu:32'h400});
      dmem_req_ready = 1;
      #1;
      total++; if (StallM !== 1'b1) begin bad++; $display("FAIL to_acc got=%0b exp=1", StallM); end
      tick(); idle_inputs();
      for (int i = 1; i < TO; i++) begin
         #1;
         total++; if (StallM !== 1'b1) begin bad++; $display("FAIL to_wait%0d got=%0b exp=1", i, StallM); end
         tick();
      end
      #1;
      total++; if ({StallM, BusErrorM} !== 2'b00) begin bad++;
         $display("FAIL to_expire got=%0b/%0b exp=0/0", StallM, BusErrorM); end
      tick();
      total++; if ({BusErrorM, RegWriteW, RD_W, ReadDataW} !== {1'b1, 1'b1, 5'd12, 32'h0}) begin bad++;
         $display("FAIL to_wb got=%0b/%0b/%0d/%h exp=1/1/12/0", BusErrorM, RegWriteW, RD_W, ReadDataW); end
      drive('{rw:1, mw:0, rs:0, rd:5'd3, pc:32'h44, wd:32'h0, alu:32'h77});
      dmem_rsp_valid = 1; dmem_rsp_rdata = 32'h55555555;
      #1;
      total++; if ({StallM, dmem_req_valid} !== 2'b00) begin bad++;
         $display("FAIL to_next got=%0b/%0b exp=0/0", StallM, dmem_req_valid); end
      tick(); idle_inputs();
      total++; if ({BusErrorM, RegWriteW, RD_W, ALU_ResultW, ReadDataW} !== {1'b1, 1'b1, 5'd3, 32'h77, 32'h0}) begin bad++;
         $display("FAIL to_after got=%0b/%0b/%0d/%h/%h exp=1/1/3/77/0", BusErrorM, RegWriteW, RD_W, ALU_ResultW, ReadDataW); end
   endtask

   task automatic test_reset_mid_load();
      drive('{rw:1, mw:0, rs:1, rd:5'd20, pc:32'h50, wd:32'h0, alu:32'h500});
      dmem_req_ready = 1;
      tick(); idle_inputs();
      #1;
      total++; if (StallM !== 1'b1) begin bad++; $display("FAIL rml_wait got=%0b exp=1", StallM); end
      rst = 1;
      #1;
      total++; if ({StallM, dmem_req_valid} !== 2'b00) begin bad++;
         $display("FAIL rml_force got=%0b/%0b exp=0/0", StallM, dmem_req_valid); end
      tick(); rst = 0;
      dmem_rsp_valid = 1; dmem_rsp_rdata = 32'h999;
      #1;
      total++; if ({StallM, dmem_req_valid, BusErrorM, RegWriteW, RD_W, ALU_ResultW, ReadDataW} !== '0) begin bad++;
         $display("FAIL rml_idle got=%0b/%0b/%0b/%0b/%0d/%h/%h exp=all0", StallM, dmem_req_valid, BusErrorM, RegWriteW, RD_W, ALU_ResultW, ReadDataW); end
      tick(); idle_inputs();
      total++; if ({RegWriteW, ReadDataW} !== 33'h0) begin bad++;
         $display("FAIL rml_ignore got=%0b/%h exp=0/0", RegWriteW, ReadDataW); end
   endtask

   // Reference: a pending access is "issued" (request not yet accepted) or
   // "accepted" (awaiting data); it completes on acceptance of a store, on a
   // response to an accepted load, or after waiting TO cycles without progress.
   task automatic test_random();
      txn_t        cur, hold, src;
      bit          busy = 0, accd = 0, done, timed, prog;
      int          waited = 0;
      logic        x_valid, x_we;
      logic [31:0] x_addr, x_wdata, x_rdata;
      logic        e_rw = 0, e_rs = 0, e_err = 0;
      logic [4:0]  e_rd = 0;
      logic [31:0] e_pc = 0, e_alu = 0, e_rdata = 0;
      hold = '0;
      rst = 1; idle_inputs(); tick(); rst = 0;
      for (int n = 0; n < 600; n++) begin
         cur.rw  = 1'($urandom_range(0, 1));
         cur.mw  = ($urandom_range(0, 3) == 0);
         cur.rs  = ($urandom_range(0, 2) == 0);
         cur.rd  = 5'($urandom_range(0, 31));
         cur.pc  = $urandom; cur.wd = $urandom; cur.alu = $urandom;
         drive(cur);
         dmem_req_ready = 1'($urandom_range(0, 1));
         dmem_rsp_valid = ($urandom_range(0, 3) == 0);
         dmem_rsp_rdata = $urandom;
         x_valid = 0; x_we = 0; x_addr = 0; x_wdata = 0; x_rdata = 0;
         done = 0; timed = 0; prog = 0;
         if (!busy) begin
            src = cur;
            if (cur.mw || cur.rs) begin
               x_valid = 1; x_we = cur.mw; x_addr = cur.alu; x_wdata = cur.wd;
            end
            done = !(cur.mw || cur.rs) || (cur.mw && dmem_req_ready);
            if (!done) begin
               busy = 1; accd = !cur.mw && dmem_req_ready; waited = 0; hold = cur;
            end
         end else begin
            src = hold;
            if (!accd) begin
               x_valid = 1; x_we = hold.mw; x_addr = hold.alu; x_wdata = hold.wd;
               if (dmem_req_ready) begin
                  prog = 1;
                  if (hold.mw) done = 1; else accd = 1;
               end
            end else if (dmem_rsp_valid) begin
               prog = 1; done = 1; x_rdata = dmem_rsp_rdata;
            end
            if (!prog && waited >= TO - 1) begin done = 1; timed = 1; end
            waited++;
            if (done) busy = 0;
         end
         #1;
         total++; if ({StallM, dmem_req_valid} !== {!done, x_valid}) begin bad++;
            $display("FAIL rnd_ctl[%0d] got=%0b/%0b exp=%0b/%0b", n, StallM, dmem_req_valid, !done, x_valid); end
         if (x_valid) begin
            total++; if ({dmem_we, dmem_addr, dmem_wdata} !== {x_we, x_addr, x_wdata}) begin bad++;
               $display("FAIL rnd_req[%0d] got=%0b/%h/%h exp=%0b/%h/%h", n, dmem_we, dmem_addr, dmem_wdata, x_we, x_addr, x_wdata); end
         end
         tick();
         if (done) begin
            e_rw = src.rw; e_rs = src.rs; e_rd = src.rd; e_pc = src.pc; e_alu = src.alu; e_rdata = x_rdata;
         end else begin
            e_rw = 0; e_rs = 0;
         end
         e_err = e_err | timed;
         total++; if ({RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW, BusErrorM} !==
                      {e_rw, e_rs, e_rd, e_pc, e_alu, e_rdata, e_err}) begin bad++;
            $display("FAIL rnd_wb[%0d] got=%h exp=%h", n, {RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW, BusErrorM},
                     {e_rw, e_rs, e_rd, e_pc, e_alu, e_rdata, e_err}); end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      test_reset();
      test_alu();
      test_store_zero_wait();
      test_store_backpressure();
      test_load();
      test_timeout();
      test_reset_mid_load();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/memory_cycle.md
# memory_cycle

Memory stage of the five-stage RISC-V pipeline. Consumes the EX/MEM register outputs of the execute stage, performs loads and stores over a valid/ready data-memory bus with variable latency, and produces the MEM/WB register outputs for writeback. It raises a stall to hold fetch, decode and execute while a load or store is outstanding. A timeout guarantees forward progress if the memory never answers.

## Interface
- TIMEOUT_CYCLES, 255: max cycles an access may wait (request + response) before forced completion; ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- RegWriteM  in  1  instruction writes the register file.
- MemWriteM  in  1  instruction is a store.
- ResultSrcM  in  1  1 = load (result from memory), 0 = ALU result.
- RD_M  in  5  destination register.
- PCPlus4M  in  32  PC+4 of the instruction.
- WriteDataM  in  32  store data.
- ALU_ResultM  in  32  effective address / ALU result.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts request.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  32  byte address, passed unmodified.
- dmem_wdata  out  32  write data.
- dmem_rsp_valid  in  1  read data valid.
- dmem_rsp_rdata  in  32  read data.
- StallM  out  1  holds all upstream pipeline registers and the PC.
- BusErrorM  out  1  sticky flag: at least one access timed out.
- RegWriteW, ResultSrcW  out  1 each  MEM/WB control.
- RD_W  out  5; PCPlus4W, ALU_ResultW, ReadDataW  out  32 each  MEM/WB data.

## Operation
- Access = MemWriteM | ResultSrcM. MemWriteM and ResultSrcM both set → treated as store; ReadDataW = 0.
- FSM states: IDLE, REQ, WAIT_RSP.
- IDLE, no access: no request, StallM=0; MEM/WB loads inputs, ReadDataW=0.
- IDLE, access: dmem_req_valid=1 combinationally; addr=ALU_ResultM, wdata=WriteDataM, we=MemWriteM. On the same edge, all inputs latch into a hold register.
  - Store with ready → completes this cycle, StallM=0, stay IDLE.
  - Store without ready → REQ.
  - Load with ready → WAIT_RSP.
  - Load without ready → REQ.
- REQ: request driven from the hold register; stable until accepted.
  - Ready with store → complete, IDLE.
  - Ready with load → WAIT_RSP.
- WAIT_RSP: dmem_req_valid=0. On dmem_rsp_valid → complete with ReadDataW=dmem_rsp_rdata, IDLE.
- dmem_rsp_valid outside WAIT_RSP is ignored.
- StallM=1 in every cycle an access is pending and does not complete that cycle.
- MEM/WB while StallM=1: bubble. RegWriteW←0, ResultSrcW←0, other fields hold.
- MEM/WB on completion: fields from the hold register, or from the inputs for a same-cycle IDLE store.
- Timeout: counter clears on leaving IDLE and increments each cycle in REQ or WAIT_RSP.
  - Reaching TIMEOUT_CYCLES forces completion: dmem_req_valid drops, ReadDataW=0, BusErrorM←1, next state IDLE.
  - A response or acceptance in the expiry cycle wins; no error is flagged.

## Timing
- Reset (rst=1 at edge): state IDLE, counter 0, BusErrorM 0, all MEM/WB outputs 0, hold register 0.
- While rst=1, dmem_req_valid and StallM are forced 0, even when inputs request an access.
- Reset mid-access abandons the access; the memory-side response is ignored afterwards.
- Latency, zero-wait store: 0 stall cycles; MEM/WB updates at the next edge.
- Latency, load: request accepted in cycle t, response in cycle t+k (k≥1) → k stall cycles after acceptance, plus any cycles spent in REQ.
- The earliest load response is the cycle after acceptance. A response in the acceptance cycle is not sampled.
- StallM is combinational from state and bus inputs; no register.
- BusErrorM is cleared only by rst.

## Structure
- Shared package `pipeline_pkg`: FSM state enum (IDLE, REQ, WAIT_RSP), XLEN=32, REG_ADDR_W=5.
- Sub-module `mem_wb_register` holds the MEM/WB pipeline register, with load-enable and bubble inputs.
- FSM, hold register and timeout counter stay in `memory_cycle`.
- Counter width is $clog2(TIMEOUT_CYCLES+1).

## Test plan
- ALU op: RegWriteM=1, RD_M=5, ALU_ResultM=0x2A, no access → no request, StallM=0; next edge RegWriteW=1, RD_W=5, ALU_ResultW=0x2A.
- Zero-wait store: MemWriteM=1, addr 0x100, data 0xDEADBEEF, ready=1 → single-cycle request (we=1), StallM=0 throughout.
- Store with backpressure: ready low 3 cycles → StallM=1 for 3 cycles, RegWriteW=0 each cycle, addr/data stable; completes on the 4th cycle.
- Load: addr 0x200, ready=1, response 2 cycles later with 0x12345678 → StallM=1 for 2 cycles; then RegWriteW=1, ResultSrcW=1, ReadDataW=0x12345678.
- Timeout: TIMEOUT_CYCLES=4, load accepted, no response → forced completion on the 4th wait cycle; BusErrorM=1 and stays 1; next instruction proceeds. A spurious later rsp_valid is ignored.
- Reset mid-load in WAIT_RSP → next cycle IDLE, all outputs 0, StallM=0; a later rsp_valid is ignored.
